// File: rtl/conv_pkg.sv
// Shared types and helpers for the FIFO-to-PE-array operand conversion path.
package conv_pkg;

    localparam int unsigned ELEM_W = 8;

    typedef logic [ELEM_W-1:0] elem_t;

    // Low-n-bits-set mask; used for per-lane keep of a partial word.
    function automatic logic [31:0] lane_mask(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains a one-cycle-latency FIFO read port and packs PACK elements per output word.
// m_ready reaches fifo_rd_en combinationally so a full-word capture can overlap a transfer.
module fifo_rd_packer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4,
    parameter int unsigned CNT_W      = $clog2(PACK + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
    input  logic                         flush,
    output logic [DATA_WIDTH*PACK-1:0]   m_data,
    output logic [PACK-1:0]              m_keep,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready
);

    logic [CNT_W-1:0]           fill_q, fill_d;
    logic                       pend_q, pend_d;
    logic                       flush_req_q, flush_req_d;
    logic [DATA_WIDTH*PACK-1:0] asm_q, asm_d;
    logic [DATA_WIDTH*PACK-1:0] m_data_q, m_data_d;
    logic [PACK-1:0]            m_keep_q, m_keep_d;
    logic                       m_last_q, m_last_d;
    logic                       m_valid_q, m_valid_d;

    logic [CNT_W:0]             cnt;
    logic                       out_free;
    logic                       flush_go;
    logic [DATA_WIDTH*PACK-1:0] part_data;

    always_comb begin
        cnt      = {1'b0, fill_q} + (CNT_W + 1)'(pend_q);
        out_free = !m_valid_q || m_ready;
        // The last-lane capture may overlap a read only if it can go straight to the output.
        fifo_rd_en = !fifo_empty && !flush_req_q &&
                     ((cnt < (CNT_W + 1)'(PACK)) ||
                      (pend_q && (fill_q == CNT_W'(PACK - 1)) && out_free));
        flush_go = flush_req_q && !pend_q && out_free;

        for (int i = 0; i < PACK; i++) begin
            part_data[i*DATA_WIDTH +: DATA_WIDTH] =
                (CNT_W'(i) < fill_q) ? asm_q[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end

        fill_d      = fill_q;
        pend_d      = fifo_rd_en;
        asm_d       = asm_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        flush_req_d = flush_req_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (flush_req_q) begin
            if (flush_go) begin
                flush_req_d = 1'b0;
            end
        end else begin
            flush_req_d = flush;
        end

        if (flush_go) begin
            if (fill_q != '0) begin
                m_data_d  = part_data;
                m_keep_d  = PACK'(lane_mask(32'(fill_q)));
                m_last_d  = 1'b1;
                m_valid_d = 1'b1;
            end
            fill_d = '0;
        end else if ((fill_q == CNT_W'(PACK)) && out_free) begin
            m_data_d  = asm_q;
            m_keep_d  = {PACK{1'b1}};
            m_last_d  = 1'b0;
            m_valid_d = 1'b1;
            fill_d    = '0;
        end else if (pend_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (fill_q == CNT_W'(i)) begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                end
            end
            if (fill_q == CNT_W'(PACK - 1)) begin
                if (out_free) begin
                    m_data_d  = asm_d;
                    m_keep_d  = {PACK{1'b1}};
                    m_last_d  = 1'b0;
                    m_valid_d = 1'b1;
                    fill_d    = '0;
                end else begin
                    fill_d = CNT_W'(PACK);
                end
            end else begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            asm_q       <= asm_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

endmodule
